// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator: correlates offset-binary ADC samples against a square-wave carrier
// reference, decides one BPSK symbol per SAMPLES_PER_SYMBOL and deframes UART-style bytes.
module bpsk_demodulator #(
    parameter int DATA_WIDTH         = 12,
    parameter int CARRIER_SAMPLES    = 8,
    parameter int SAMPLES_PER_SYMBOL = 32,
    parameter int THRESHOLD          = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic [7:0]            data_out,
    output logic                  data_valid,
    output logic                  frame_error,
    output logic                  carrier_detect
);
    localparam int ACC_W = DATA_WIDTH + 1 + $clog2(SAMPLES_PER_SYMBOL);
    localparam int P_W   = $clog2(CARRIER_SAMPLES);
    localparam int N_W   = $clog2(SAMPLES_PER_SYMBOL);
    localparam logic [P_W-1:0]   P_LAST = P_W'(CARRIER_SAMPLES - 1);
    localparam logic [P_W-1:0]   P_HALF = P_W'(CARRIER_SAMPLES / 2);
    localparam logic [N_W-1:0]   N_LAST = N_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [ACC_W-1:0] TH     = ACC_W'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    logic [P_W-1:0]          p;
    logic [N_W-1:0]          n;
    logic signed [DATA_WIDTH:0] s;
    logic signed [DATA_WIDTH:0] term;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sym_acc;
    logic                    sym_stb;
    logic                    sym_last;
    logic [ACC_W-1:0]        mag;
    logic                    present;
    logic                    sym_bit;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] data_out_n;
    logic       data_valid_n;
    logic       frame_error_n;
    logic       carrier_detect_n;

    // Offset-binary to two's complement is an MSB flip; one extra bit keeps -s exact.
    assign s        = {~sample_in[DATA_WIDTH-1], ~sample_in[DATA_WIDTH-1], sample_in[DATA_WIDTH-2:0]};
    assign term     = (p < P_HALF) ? s : -s;
    assign sum      = acc + ACC_W'(term);
    assign sym_last = (n == N_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p       <= '0;
            n       <= '0;
            acc     <= '0;
            sym_acc <= '0;
            sym_stb <= 1'b0;
        end else begin
            sym_stb <= 1'b0;
            if (sample_en) begin
                p   <= (p == P_LAST) ? '0 : p + 1'b1;
                n   <= sym_last ? '0 : n + 1'b1;
                acc <= sym_last ? '0 : sum;
                if (sym_last) begin
                    sym_acc <= sum;
                    sym_stb <= 1'b1;
                end
            end
        end
    end

    // The full symbol sum is registered so the decision runs a cycle later without stalling accumulation.
    assign mag     = sym_acc[ACC_W-1] ? -sym_acc : sym_acc;
    assign present = mag >= TH;
    assign sym_bit = ~sym_acc[ACC_W-1] & (|sym_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shreg          <= '0;
            data_out       <= '0;
            data_valid     <= 1'b0;
            frame_error    <= 1'b0;
            carrier_detect <= 1'b0;
        end else begin
            state          <= state_n;
            bit_cnt        <= bit_cnt_n;
            shreg          <= shreg_n;
            data_out       <= data_out_n;
            data_valid     <= data_valid_n;
            frame_error    <= frame_error_n;
            carrier_detect <= carrier_detect_n;
        end
    end

    always_comb begin
        state_n          = state;
        bit_cnt_n        = bit_cnt;
        shreg_n          = shreg;
        data_out_n       = data_out;
        data_valid_n     = 1'b0;
        frame_error_n    = 1'b0;
        carrier_detect_n = carrier_detect;
        if (sym_stb) begin
            carrier_detect_n = present;
            case (state)
                IDLE: begin
                    if (present && !sym_bit) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    if (!present) begin
                        state_n = IDLE;
                    end else begin
                        shreg_n   = {sym_bit, shreg[7:1]};
                        bit_cnt_n = bit_cnt + 1'b1;
                        state_n   = (bit_cnt == 3'd7) ? STOP : DATA;
                    end
                end
                STOP: begin
                    state_n = IDLE;
                    if (present && sym_bit) begin
                        data_out_n   = shreg;
                        data_valid_n = 1'b1;
                    end else if (present) begin
                        frame_error_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
